lc3_control: RTL

Sequencing FSM for the LC-3 datapath. It decodes `IR` and drives every datapath select, load, enable and tri-state control, plus a single-port memory request/ready handshake. Per instruction it runs fetch, decode and execute, ensuring at most one bus driver is enabled in any cycle. It sits beside the datapath and is instantiated with it under the top-level LC-3 wrapper.

---
 rtl/lc3_control.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/lc3_control.sv
// lc3_control: sequencing FSM for the LC-3 datapath.
// Runs fetch / decode / execute per instruction and drives every datapath
// select, load, bus tri-state enable and the memory request handshake.
// Optional feature: define LC3_CTRL_IND_EN to support LDI (1010) / STI (1011);
// without it those opcodes are treated as illegal.
// Ports:
//   clk, rst (async active-low)       clock / reset
//   IR[15:0], N, Z, P                 instruction and condition flags
//   mem_rdy / mem_en, mem_we          memory handshake
//   enaALU, enaMARM, enaPC, enaMDR    bus drivers (at most one high)
//   ldPC, ldIR, ldMAR, ldMDR          register loads
//   regWE, flagWE                     register file / flag writes
//   selEAB1, selEAB2, selPC, selMAR,
//   selMDR, aluControl                datapath selects
//   SR1, SR2, DR                      register file addresses
//   illegal_op                        one-cycle pulse on unsupported opcode
module lc3_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic        mem_rdy,
  output logic        mem_en,
  output logic        mem_we,
  output logic        enaALU,
  output logic        enaMARM,
  output logic        enaPC,
  output logic        enaMDR,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        regWE,
  output logic        flagWE,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic [1:0]  selPC,
  output logic        selMAR,
  output logic        selMDR,
  output logic [1:0]  aluControl,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [2:0]  DR,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    FETCH0, FETCH1, FETCH2, DECODE,
    EX_ALU, EX_BR, EX_JMP, EX_LEA,
    ADDR, MEM_RD, WB, ST_DATA, MEM_WR,
    IND_RD, IND_MAR
  } state_t;

  state_t      state;
  state_t      dispatch;
  state_t      addr_next;
  logic        legal;
  logic        ind_op;
  logic        br_taken;
  logic [3:0]  op;

  assign op       = IR[15:12];
  assign br_taken = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);

`ifdef LC3_CTRL_IND_EN
  assign ind_op = (op == 4'b1010) || (op == 4'b1011);
`else
  assign ind_op = 1'b0;
`endif

  // Store-class opcodes (ST/STR/STI) all have op[0]=1; loads have op[0]=0.
  assign addr_next = ind_op ? IND_RD : (op[0] ? ST_DATA : MEM_RD);

  always_comb begin
    dispatch = FETCH0;
    legal    = 1'b1;
    case (op)
      4'b0001, 4'b0101, 4'b1001:          dispatch = EX_ALU;
      4'b0000:                            dispatch = EX_BR;
      4'b1100:                            dispatch = EX_JMP;
      4'b1110:                            dispatch = EX_LEA;
      4'b0010, 4'b0110, 4'b0011, 4'b0111: dispatch = ADDR;
      4'b1010, 4'b1011: begin
        dispatch = ind_op ? ADDR : FETCH0;
        legal    = ind_op;
      end
      default:                            legal    = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH0;
    end else begin
      case (state)
        FETCH0:  state <= FETCH1;
        FETCH1:  if (mem_rdy) state <= FETCH2;
        FETCH2:  state <= DECODE;
        DECODE:  state <= dispatch;
        ADDR:    state <= addr_next;
        MEM_RD:  if (mem_rdy) state <= WB;
        ST_DATA: state <= MEM_WR;
        MEM_WR:  if (mem_rdy) state <= FETCH0;
        IND_RD:  if (mem_rdy) state <= IND_MAR;
        IND_MAR: state <= op[0] ? ST_DATA : MEM_RD;
        default: state <= FETCH0;
      endcase
    end
  end

  // Outputs are a pure decode of state/IR/flags/mem_rdy, forced to zero
  // while reset is held so an in-flight access is dropped at once.
  always_comb begin
    mem_en = 1'b0; mem_we = 1'b0;
    enaALU = 1'b0; enaMARM = 1'b0; enaPC = 1'b0; enaMDR = 1'b0;
    ldPC = 1'b0; ldIR = 1'b0; ldMAR = 1'b0; ldMDR = 1'b0;
    regWE = 1'b0; flagWE = 1'b0;
    selEAB1 = 1'b0; selEAB2 = 2'b00; selPC = 2'b00;
    selMAR = 1'b0; selMDR = 1'b0; aluControl = 2'b00;
    SR1 = 3'd0; SR2 = 3'd0; DR = 3'd0;
    illegal_op = 1'b0;
    if (rst) begin
      SR1 = (state == ST_DATA) ? IR[11:9] : IR[8:6];
      SR2 = IR[2:0];
      DR  = IR[11:9];
      case (state)
        FETCH0: begin
          enaPC = 1'b1; ldMAR = 1'b1; ldPC = 1'b1;
        end
        FETCH1, MEM_RD, IND_RD: begin
          mem_en = 1'b1;
          if (mem_rdy) begin
            selMDR = 1'b1; ldMDR = 1'b1;
          end
        end
        FETCH2: begin
          enaMDR = 1'b1; ldIR = 1'b1;
        end
        DECODE: illegal_op = ~legal;
        EX_ALU: begin
          enaALU = 1'b1; regWE = 1'b1; flagWE = 1'b1;
          aluControl = (op == 4'b0001) ? 2'b00 :
                       (op == 4'b0101) ? 2'b01 : 2'b10;
        end
        EX_BR: if (br_taken) begin
          selEAB2 = 2'b10; selPC = 2'b01; ldPC = 1'b1;
        end
        EX_JMP: begin
          selEAB1 = 1'b1; selPC = 2'b01; ldPC = 1'b1;
        end
        EX_LEA: begin
          selEAB2 = 2'b10; enaMARM = 1'b1; regWE = 1'b1; flagWE = 1'b1;
        end
        ADDR: begin
          enaMARM = 1'b1; ldMAR = 1'b1;
          // Base+offset6 for LDR/STR (op[2]=1), PC+offset9 otherwise.
          selEAB1 = op[2];
          selEAB2 = op[2] ? 2'b01 : 2'b10;
        end
        WB: begin
          enaMDR = 1'b1; regWE = 1'b1; flagWE = 1'b1;
        end
        ST_DATA: begin
          aluControl = 2'b11; enaALU = 1'b1; ldMDR = 1'b1;
        end
        MEM_WR: begin
          mem_en = 1'b1; mem_we = 1'b1;
        end
        IND_MAR: begin
          enaMDR = 1'b1; ldMAR = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
